reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32 x 32-bit MIPS general-purpose register file for the single-cycle processor.
- Sits directly downstream of the RegDst write-address selector, which drives write_reg.
- Also consumes the write-back data and the RegWrite control.
- Provides two combinational read ports (rs, rt) to the ALU/operand path and one debug read port for the testbench and display logic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- SP_INIT, 32'h0000_3FFC, reset value of register 29 ($sp).
- GP_INIT, 32'h0000_1800, reset value of register 28 ($gp).
- WRITE_THROUGH, 0, when 1 a same-cycle read of the register being written returns write_data.

Ports:
- clk  in  1  system clock; all writes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RegWrite  in  1  write enable from the control unit.
- read_reg1  in  ADDR_W  rs address.
- read_reg2  in  ADDR_W  rt address.
- write_reg  in  ADDR_W  destination address from the RegDst selector.
- write_data  in  DATA_W  write-back value.
- read_data1  out  DATA_W  contents of read_reg1.
- read_data2  out  DATA_W  contents of read_reg2.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  contents of dbg_addr.

Behaviour:
- Reset:
  - rst_n low clears every register to 0 immediately, without waiting for clk.
  - Exceptions: reg 28 loads GP_INIT and reg 29 loads SP_INIT.
  - Read outputs reflect the reset contents combinationally while reset is held.
  - A write coinciding with reset assertion is discarded.
  - Deassertion is sampled by the next rising edge; the first write takes effect at the first rising edge with rst_n high.
- Write:
  - On posedge clk with rst_n=1 and RegWrite=1, regs[write_reg] <= write_data.
  - Single-cycle latency: the new value is visible on the read ports after that edge.
  - When RegWrite=0, write_reg and write_data are don't-care, including X; no register may change.
- Register 0:
  - Hardwired to 0. Writes to address 0 are silently dropped.
  - Any read of address 0 on any port returns 0 regardless of storage.
- Reads:
  - Purely combinational: read_dataN = regs[read_regN], and dbg_data likewise.
  - No clock latency.
  - Both read ports may address the same register simultaneously.
- Simultaneous read/write of the same nonzero address:
  - WRITE_THROUGH=0: the read returns the old value until the edge.
  - WRITE_THROUGH=1 and RegWrite=1: the read returns write_data in the same cycle.
  - The dbg port never bypasses.
- Widths: no arithmetic; data passes unmodified, no sign or zero extension.
- No state machine beyond the storage array. The block must not generate any combinational loop from read to write.

Decomposition:
- Shared package mips_pkg:
  - DATA_W and ADDR_W constants.
  - Register indices REG_ZERO=0, REG_GP=28, REG_SP=29, REG_RA=31.
  - reg_addr_t and word_t typedefs.
- Read-port mux replicated three times: factor into one sub-module reg_read_port. It takes address, array view, bypass enable, write_reg, write_data and RegWrite, and returns the data.
- Storage and the write logic stay in reg_file.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 with clk running, RegWrite=1, write_reg=5, write_data=32'hDEAD_BEEF.
  - Response: dbg_addr sweep 0..31 returns 0 everywhere, except 28 = 32'h0000_1800 and 29 = 32'h0000_3FFC; reg 5 stays 0.
- Basic write/read:
  - Stimulus: write 32'h1234_5678 to reg 8, then read_reg1=8, read_reg2=8.
  - Response: both ports read 32'h1234_5678 after the edge, not before (WRITE_THROUGH=0).
- Zero register:
  - Stimulus: RegWrite=1, write_reg=0, write_data=32'hFFFF_FFFF.
  - Response: read_data1 with read_reg1=0 remains 0.
- Write disable:
  - Stimulus: RegWrite=0, write_reg=9, write_data=32'hAAAA_AAAA, after reg 9 was loaded with 32'h5.
  - Response: reg 9 still reads 32'h5.
- Bypass:
  - Stimulus: with WRITE_THROUGH=1, reg 10 holds 1; drive RegWrite=1, write_reg=10, write_data=2, read_reg2=10.
  - Response: read_data2=2 before the edge and dbg_data=1 before the edge; both read 2 after the edge.
- Mid-operation reset:
  - Stimulus: write 32'h77 to regs 1..31, then pulse rst_n low between edges.
  - Response: all registers return to their reset values immediately, before the next clk edge; a write on the first post-release edge (reg 3 <= 32'h9) lands.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS datapath widths, register indices and types
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_GP = 5'd28;
  localparam logic [ADDR_W-1:0] REG_SP = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA = 5'd31;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: register file write, operand read and debug read signals
interface reg_file_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic RegWrite;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] dbg_data;
  modport master (
    output RegWrite, read_reg1, read_reg2, write_reg, write_data, dbg_addr,
    input read_data1, read_data2, dbg_data
  );
  modport slave (
    input RegWrite, read_reg1, read_reg2, write_reg, write_data, dbg_addr,
    output read_data1, read_data2, dbg_data
  );
endinterface

// File: rtl/reg_read_port.sv
// reg_read_port: combinational register read with $zero masking and optional write bypass
module reg_read_port import mips_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]     regs,
  input  logic                                 bypass,
  input  logic [ADDR_W-1:0]                    write_reg,
  input  logic [DATA_W-1:0]                    write_data,
  input  logic                                 reg_write,
  output logic [DATA_W-1:0]                    data
);
  always_comb data = (addr == REG_ZERO) ? '0 :
                     (bypass && reg_write && addr == write_reg) ? write_data : regs[addr];
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 MIPS register file, two operand read ports plus a non-bypassing debug port
module reg_file import mips_pkg::*; #(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 5,
  parameter logic [DATA_W-1:0] SP_INIT       = 32'h0000_3FFC,
  parameter logic [DATA_W-1:0] GP_INIT       = 32'h0000_1800,
  parameter bit                WRITE_THROUGH = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  reg_file_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  always_comb begin
    regs_d = regs_q;
    if (bus.RegWrite && bus.write_reg != REG_ZERO) regs_d[bus.write_reg] = bus.write_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= (ADDR_W'(i) == REG_GP) ? GP_INIT : (ADDR_W'(i) == REG_SP) ? SP_INIT : '0;
    else
      regs_q <= regs_d;
  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .addr(bus.read_reg1), .regs(regs_q), .bypass(WRITE_THROUGH), .write_reg(bus.write_reg),
    .write_data(bus.write_data), .reg_write(bus.RegWrite), .data(bus.read_data1)
  );
  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .addr(bus.read_reg2), .regs(regs_q), .bypass(WRITE_THROUGH), .write_reg(bus.write_reg),
    .write_data(bus.write_data), .reg_write(bus.RegWrite), .data(bus.read_data2)
  );
  // the debug view always shows committed storage, never the in-flight write
  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
    .addr(bus.dbg_addr), .regs(regs_q), .bypass(1'b0), .write_reg(bus.write_reg),
    .write_data(bus.write_data), .reg_write(bus.RegWrite), .data(bus.dbg_data)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks of reg_file with and without write-through
module tb_reg_file;
  localparam logic [31:0] SP = 32'h0000_3FFC;
  localparam logic [31:0] GP = 32'h0000_1800;
  logic clk;
  logic rst_n;
  int pass = 0;
  int total = 0;
  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
  reg_file #(.WRITE_THROUGH(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  reg_file #(.WRITE_THROUGH(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  initial clk = 1'b0;
  always #50 clk = ~clk;
  task automatic set_wr(input logic we, input logic [4:0] wr, input logic [31:0] wd);
    bus0.RegWrite = we; bus0.write_reg = wr; bus0.write_data = wd;
    bus1.RegWrite = we; bus1.write_reg = wr; bus1.write_data = wd;
  endtask
  task automatic set_rd(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    bus0.read_reg1 = r1; bus0.read_reg2 = r2; bus0.dbg_addr = d;
    bus1.read_reg1 = r1; bus1.read_reg2 = r2; bus1.dbg_addr = d;
  endtask
  task automatic test_reset;
    logic [31:0] e;
    rst_n = 1'b0;
    set_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    set_rd(5'd29, 5'd28, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus0.read_data1 !== SP) $display("FAIL rst_rd1_sp: got %h want %h", bus0.read_data1, SP); else pass++;
    total++; if (bus0.read_data2 !== GP) $display("FAIL rst_rd2_gp: got %h want %h", bus0.read_data2, GP); else pass++;
    for (int i = 0; i < 32; i++) begin
      bus0.dbg_addr = 5'(i);
      #1;
      e = (i == 28) ? GP : (i == 29) ? SP : 32'h0;
      total++; if (bus0.dbg_data !== e) $display("FAIL rst_dbg[%0d]: got %h want %h", i, bus0.dbg_data, e); else pass++;
    end
  endtask
  task automatic test_basic;
    @(negedge clk);
    rst_n = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    set_wr(1'b1, 5'd8, 32'h1234_5678);
    set_rd(5'd8, 5'd8, 5'd8);
    #1;
    total++; if (bus0.read_data1 !== 32'h0) $display("FAIL basic_rd1_pre: got %h want %h", bus0.read_data1, 32'h0); else pass++;
    total++; if (bus0.read_data2 !== 32'h0) $display("FAIL basic_rd2_pre: got %h want %h", bus0.read_data2, 32'h0); else pass++;
    @(posedge clk); #1;
    total++; if (bus0.read_data1 !== 32'h1234_5678) $display("FAIL basic_rd1_post: got %h want %h", bus0.read_data1, 32'h1234_5678); else pass++;
    total++; if (bus0.read_data2 !== 32'h1234_5678) $display("FAIL basic_rd2_post: got %h want %h", bus0.read_data2, 32'h1234_5678); else pass++;
    total++; if (bus0.dbg_data !== 32'h1234_5678) $display("FAIL basic_dbg_post: got %h want %h", bus0.dbg_data, 32'h1234_5678); else pass++;
  endtask
  task automatic test_zero;
    @(negedge clk);
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    total++; if (bus0.read_data1 !== 32'h0) $display("FAIL zero_rd1: got %h want %h", bus0.read_data1, 32'h0); else pass++;
    total++; if (bus0.read_data2 !== 32'h0) $display("FAIL zero_rd2: got %h want %h", bus0.read_data2, 32'h0); else pass++;
    total++; if (bus0.dbg_data !== 32'h0) $display("FAIL zero_dbg: got %h want %h", bus0.dbg_data, 32'h0); else pass++;
  endtask
  task automatic test_write_disable;
    @(negedge clk);
    set_wr(1'b1, 5'd9, 32'h5);
    @(negedge clk);
    set_wr(1'b0, 5'd9, 32'hAAAA_AAAA);
    set_rd(5'd9, 5'd8, 5'd9);
    @(posedge clk); #1;
    total++; if (bus0.read_data1 !== 32'h5) $display("FAIL wdis_rd1: got %h want %h", bus0.read_data1, 32'h5); else pass++;
    @(negedge clk);
    set_wr(1'b0, 5'bx, 32'bx);
    @(posedge clk); #1;
    total++; if (bus0.read_data1 !== 32'h5) $display("FAIL wdis_x_rd1: got %h want %h", bus0.read_data1, 32'h5); else pass++;
    total++; if (bus0.read_data2 !== 32'h1234_5678) $display("FAIL wdis_x_rd2: got %h want %h", bus0.read_data2, 32'h1234_5678); else pass++;
    total++; if (bus1.dbg_data !== 32'h5) $display("FAIL wdis_x_wt_dbg: got %h want %h", bus1.dbg_data, 32'h5); else pass++;
  endtask
  task automatic test_bypass;
    @(negedge clk);
    set_wr(1'b1, 5'd10, 32'h1);
    @(negedge clk);
    set_wr(1'b1, 5'd10, 32'h2);
    set_rd(5'd10, 5'd10, 5'd10);
    #1;
    total++; if (bus1.read_data2 !== 32'h2) $display("FAIL byp_wt_rd2_pre: got %h want %h", bus1.read_data2, 32'h2); else pass++;
    total++; if (bus1.read_data1 !== 32'h2) $display("FAIL byp_wt_rd1_pre: got %h want %h", bus1.read_data1, 32'h2); else pass++;
    total++; if (bus1.dbg_data !== 32'h1) $display("FAIL byp_wt_dbg_pre: got %h want %h", bus1.dbg_data, 32'h1); else pass++;
    total++; if (bus0.read_data2 !== 32'h1) $display("FAIL byp_nowt_rd2_pre: got %h want %h", bus0.read_data2, 32'h1); else pass++;
    @(posedge clk); #1;
    total++; if (bus1.read_data2 !== 32'h2) $display("FAIL byp_wt_rd2_post: got %h want %h", bus1.read_data2, 32'h2); else pass++;
    total++; if (bus1.dbg_data !== 32'h2) $display("FAIL byp_wt_dbg_post: got %h want %h", bus1.dbg_data, 32'h2); else pass++;
    total++; if (bus0.read_data2 !== 32'h2) $display("FAIL byp_nowt_rd2_post: got %h want %h", bus0.read_data2, 32'h2); else pass++;
    @(negedge clk);
    set_wr(1'b0, 5'd10, 32'h3);
    #1;
    total++; if (bus1.read_data2 !== 32'h2) $display("FAIL byp_wt_disabled: got %h want %h", bus1.read_data2, 32'h2); else pass++;
    set_wr(1'b1, 5'd0, 32'h5);
    set_rd(5'd0, 5'd10, 5'd10);
    #1;
    total++; if (bus1.read_data1 !== 32'h0) $display("FAIL byp_wt_zero: got %h want %h", bus1.read_data1, 32'h0); else pass++;
  endtask
  task automatic test_mid_reset;
    logic [31:0] e;
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      set_wr(1'b1, 5'(r), 32'h77);
    end
    @(negedge clk);
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(5'd3, 5'd31, 5'd29);
    #1;
    total++; if (bus0.read_data2 !== 32'h77) $display("FAIL mid_pre_r31: got %h want %h", bus0.read_data2, 32'h77); else pass++;
    total++; if (bus0.dbg_data !== 32'h77) $display("FAIL mid_pre_r29: got %h want %h", bus0.dbg_data, 32'h77); else pass++;
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    set_wr(1'b1, 5'd3, 32'h9);
    for (int i = 0; i < 32; i++) begin
      bus0.dbg_addr = 5'(i);
      #1;
      e = (i == 28) ? GP : (i == 29) ? SP : 32'h0;
      total++; if (bus0.dbg_data !== e) $display("FAIL mid_rst_dbg[%0d]: got %h want %h", i, bus0.dbg_data, e); else pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_rd(5'd3, 5'd4, 5'd3);
    #1;
    total++; if (bus0.read_data1 !== 32'h0) $display("FAIL mid_r3_pre: got %h want %h", bus0.read_data1, 32'h0); else pass++;
    @(posedge clk); #1;
    total++; if (bus0.read_data1 !== 32'h9) $display("FAIL mid_r3_post: got %h want %h", bus0.read_data1, 32'h9); else pass++;
    total++; if (bus0.dbg_data !== 32'h9) $display("FAIL mid_r3_dbg: got %h want %h", bus0.dbg_data, 32'h9); else pass++;
    total++; if (bus0.read_data2 !== 32'h0) $display("FAIL mid_r4: got %h want %h", bus0.read_data2, 32'h0); else pass++;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_write_disable;
    test_bypass;
    test_mid_reset;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
